// File: rtl/tx_frame_sched.sv
// Two-source round-robin frame scheduler feeding the 10G MAC TX engine.
// Counts queued frames per source, issues one tx_start per frame, tracks tx_idle.
`default_nettype none

module tx_frame_sched #(
  parameter int CNT_W    = 8,
  parameter int START_TO = 64
) (
  input  logic        wrclk_sig,
  input  logic        rst,
  input  logic        src0_frame,
  input  logic [15:0] src0_len,
  input  logic        src1_frame,
  input  logic [15:0] src1_len,
  input  logic        tx_idle,
  output logic        tx_start,
  output logic [15:0] data_length,
  output logic [1:0]  grant,
  output logic [1:0]  src_done,
  output logic        busy,
  output logic        err_ovf,
  output logic        err_to
);

  localparam int TW = $clog2(START_TO) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(START_TO - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t         state;
  logic           sel;
  logic           last_grant;
  logic [TW-1:0]  timer;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic           dec0;
  logic           dec1;
  logic           pick;
  logic           any_req;

  always_comb begin
    dec0    = (state == S_DONE) && !sel;
    dec1    = (state == S_DONE) && sel;
    any_req = (cnt0 != '0) || (cnt1 != '0);
    pick    = 1'b0;
    if ((cnt0 != '0) && (cnt1 != '0))
      pick = ~last_grant;
    else if (cnt1 != '0)
      pick = 1'b1;
  end

  // A new frame and a completion in the same cycle cancel out.
  always_ff @(posedge wrclk_sig) begin
    if (rst) begin
      cnt0    <= '0;
      cnt1    <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (src0_frame && !dec0) begin
        if (cnt0 == C_MAX)
          err_ovf <= 1'b1;
        else
          cnt0 <= cnt0 + 1'b1;
      end else if (!src0_frame && dec0 && (cnt0 != '0)) begin
        cnt0 <= cnt0 - 1'b1;
      end
      if (src1_frame && !dec1) begin
        if (cnt1 == C_MAX)
          err_ovf <= 1'b1;
        else
          cnt1 <= cnt1 + 1'b1;
      end else if (!src1_frame && dec1 && (cnt1 != '0)) begin
        cnt1 <= cnt1 - 1'b1;
      end
    end
  end

  always_ff @(posedge wrclk_sig) begin
    if (rst) begin
      state       <= S_IDLE;
      sel         <= 1'b0;
      last_grant  <= 1'b1;
      timer       <= '0;
      tx_start    <= 1'b0;
      data_length <= '0;
      grant       <= 2'b00;
      src_done    <= 2'b00;
      busy        <= 1'b0;
      err_to      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      src_done <= 2'b00;
      unique case (state)
        S_IDLE: begin
          if (tx_idle && any_req) begin
            sel         <= pick;
            data_length <= pick ? src1_len : src0_len;
            grant       <= pick ? 2'b10 : 2'b01;
            tx_start    <= 1'b1;
            busy        <= 1'b1;
            state       <= S_START;
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!tx_idle) begin
            state <= S_SEND;
          end else if (timer == T_LAST) begin
            // Abort leaves the count alone so the frame is retried.
            err_to <= 1'b1;
            grant  <= 2'b00;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SEND: begin
          if (tx_idle) begin
            src_done <= sel ? 2'b10 : 2'b01;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          last_grant <= sel;
          grant      <= 2'b00;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_frame_sched.sv
// Bench for tx_frame_sched: vector table of queue patterns plus
// hand sequences for latency, overflow, start timeout, idle gating, reset.
`timescale 1ns/1ps

module tb_tx_frame_sched;

  logic        wrclk_sig = 1'b0;
  logic        rst = 1'b1;
  logic        src0_frame = 1'b0;
  logic [15:0] src0_len = '0;
  logic        src1_frame = 1'b0;
  logic [15:0] src1_len = '0;
  logic        tx_idle = 1'b1;
  logic        tx_start;
  logic [15:0] data_length;
  logic [1:0]  grant;
  logic [1:0]  src_done;
  logic        busy;
  logic        err_ovf;
  logic        err_to;

  tx_frame_sched #(.CNT_W(8), .START_TO(64)) dut (
    .wrclk_sig   (wrclk_sig),
    .rst         (rst),
    .src0_frame  (src0_frame),
    .src0_len    (src0_len),
    .src1_frame  (src1_frame),
    .src1_len    (src1_len),
    .tx_idle     (tx_idle),
    .tx_start    (tx_start),
    .data_length (data_length),
    .grant       (grant),
    .src_done    (src_done),
    .busy        (busy),
    .err_ovf     (err_ovf),
    .err_to      (err_to)
  );

  always #5 wrclk_sig = ~wrclk_sig;

  typedef struct {
    logic [1:0]  g;
    logic [15:0] len;
    bit          src;
  } exp_t;

  typedef struct {
    int          n0;
    int          n1;
    logic [15:0] len0;
    logic [15:0] len1;
    int          exp_starts;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_starts = 0;
  int   n_done = 0;
  bit   cur_src = 1'b0;
  bit   m_lg = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every start must match the next expected grant.
  always @(negedge wrclk_sig) begin
    if (tx_start) begin
      n_starts++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_start: grant=%b len=%0d", grant, data_length);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cur_src = e.src;
        if (grant !== e.g || data_length !== e.len) begin
          bad++;
          $display("FAIL start_match: got g=%b len=%0d want g=%b len=%0d",
                   grant, data_length, e.g, e.len);
        end
      end
    end
    if (src_done != 2'b00) begin
      n_done++;
      total++;
      if (src_done !== (cur_src ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL done_src: got %b want %b", src_done,
                 cur_src ? 2'b10 : 2'b01);
      end
    end
    if (!rst) begin
      total++;
      if (busy ? !$onehot(grant) : (grant !== 2'b00)) begin
        bad++;
        $display("FAIL grant_shape: busy=%b grant=%b", busy, grant);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    m_lg = 1'b1;
    repeat (2) @(negedge wrclk_sig);
    rst = 1'b0;
  endtask

  task automatic push_exp(input bit s, input logic [15:0] len);
    exp_t e;
    e.g   = s ? 2'b10 : 2'b01;
    e.len = len;
    e.src = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_start();
    int i;
    for (i = 0; i < 200 && !tx_start; i++) @(negedge wrclk_sig);
    chk("start_timeout", {31'd0, tx_start}, 32'd1);
  endtask

  // MAC model for one frame: drop idle after drop_dly, stay busy busy_len.
  task automatic serve_frame(input int drop_dly, input int busy_len);
    wait_start();
    repeat (drop_dly) @(negedge wrclk_sig);
    tx_idle = 1'b0;
    repeat (busy_len) @(negedge wrclk_sig);
    tx_idle = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge wrclk_sig);
      if (src_done != 2'b00) break;
    end
    chk("done_timeout", {31'd0, src_done != 2'b00}, 32'd1);
  endtask

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2, 2, 16'd1448, 16'd128, 4};
    vecs[1] = '{0, 3, 16'd60,   16'd64,  3};
    vecs[2] = '{3, 1, 16'd100,  16'd200, 4};
    vecs[3] = '{1, 0, 16'd1448, 16'd0,   1};

    @(negedge wrclk_sig);
    do_reset();
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_outs", {data_length, grant, src_done, busy, err_ovf, err_to},
        32'd0);
    chk("rst_cnt", {dut.cnt1, dut.cnt0}, 32'd0);
    chk("rst_last_grant", {31'd0, dut.last_grant}, 32'd1);

    // Single frame latency and length hold.
    tx_idle = 1'b1;
    src0_len = 16'd1448;
    push_exp(1'b0, 16'd1448);
    src0_frame = 1'b1;
    @(negedge wrclk_sig);
    src0_frame = 1'b0;
    chk("t1_cnt0_c1", dut.cnt0, 32'd1);
    chk("t1_no_start_c1", {31'd0, tx_start}, 32'd0);
    @(negedge wrclk_sig);
    chk("t1_start_c2", {31'd0, tx_start}, 32'd1);
    chk("t1_grant", grant, 32'd1);
    chk("t1_len", data_length, 32'd1448);
    src0_len = 16'd7;
    begin
      int nd;
      nd = n_done;
      serve_frame(3, 100);
      chk("t1_len_held", data_length, 32'd1448);
      chk("t1_done", src_done, 32'd1);
      repeat (5) @(negedge wrclk_sig);
      chk("t1_done_once", n_done - nd, 32'd1);
      chk("t1_cnt0_end", dut.cnt0, 32'd0);
    end

    // Table: queue while MAC busy, then drain; RR order from bench model.
    do_reset();
    for (int v = 0; v < 4; v++) begin
      int r0, r1, ns;
      bit p;
      tx_idle = 1'b0;
      src0_len = vecs[v].len0;
      src1_len = vecs[v].len1;
      for (int i = 0; i < 4; i++) begin
        src0_frame = (i < vecs[v].n0);
        src1_frame = (i < vecs[v].n1);
        @(negedge wrclk_sig);
      end
      src0_frame = 1'b0;
      src1_frame = 1'b0;
      r0 = vecs[v].n0;
      r1 = vecs[v].n1;
      while (r0 + r1 > 0) begin
        if (r0 > 0 && r1 > 0) p = ~m_lg;
        else p = (r1 > 0);
        push_exp(p, p ? vecs[v].len1 : vecs[v].len0);
        m_lg = p;
        if (p) r1--; else r0--;
      end
      ns = n_starts;
      tx_idle = 1'b1;
      for (int f = 0; f < vecs[v].n0 + vecs[v].n1; f++)
        serve_frame(2, $urandom_range(1, 6));
      repeat (4) @(negedge wrclk_sig);
      chk("vec_starts", n_starts - ns, vecs[v].exp_starts);
      chk("vec_cnt_zero", {dut.cnt1, dut.cnt0}, 32'd0);
      chk("vec_q_empty", exp_q.size(), 32'd0);
    end

    // Simultaneous frame + DONE, then saturation.
    do_reset();
    tx_idle = 1'b0;
    src0_len = 16'd300;
    src0_frame = 1'b1;
    repeat (2) @(negedge wrclk_sig);
    src0_frame = 1'b0;
    push_exp(1'b0, 16'd300);
    tx_idle = 1'b1;
    serve_frame(2, 5);
    src0_frame = 1'b1;
    tx_idle = 1'b0;
    @(negedge wrclk_sig);
    src0_frame = 1'b0;
    chk("t3_cnt_same", dut.cnt0, 32'd2);
    src0_frame = 1'b1;
    repeat (253) @(negedge wrclk_sig);
    chk("t3_cnt_max", dut.cnt0, 32'd255);
    chk("t3_ovf_before", {31'd0, err_ovf}, 32'd0);
    repeat (2) @(negedge wrclk_sig);
    src0_frame = 1'b0;
    chk("t3_cnt_sat", dut.cnt0, 32'd255);
    chk("t3_ovf_after", {31'd0, err_ovf}, 32'd1);

    // Start timeout then retry of the same source.
    do_reset();
    tx_idle = 1'b1;
    src1_len = 16'd512;
    push_exp(1'b1, 16'd512);
    push_exp(1'b1, 16'd512);
    src1_frame = 1'b1;
    @(negedge wrclk_sig);
    src1_frame = 1'b0;
    wait_start();
    repeat (64) @(negedge wrclk_sig);
    chk("t4_to_before", {err_to, grant}, 32'b0_10);
    @(negedge wrclk_sig);
    chk("t4_to_after", {err_to, busy, grant}, 32'b1_0_00);
    chk("t4_cnt_kept", dut.cnt1, 32'd1);
    serve_frame(3, 10);
    @(negedge wrclk_sig);
    chk("t4_cnt_end", dut.cnt1, 32'd0);
    chk("t4_to_sticky", {31'd0, err_to}, 32'd1);

    // tx_idle low in IDLE gates starts.
    begin
      int ns;
      tx_idle = 1'b0;
      src1_len = 16'd77;
      src1_frame = 1'b1;
      repeat (3) @(negedge wrclk_sig);
      src1_frame = 1'b0;
      ns = n_starts;
      repeat (10) @(negedge wrclk_sig);
      chk("t5_no_start", n_starts - ns, 32'd0);
      chk("t5_cnt1", dut.cnt1, 32'd3);
      for (int i = 0; i < 3; i++) push_exp(1'b1, 16'd77);
      tx_idle = 1'b1;
      @(negedge wrclk_sig);
      chk("t5_start_next", {31'd0, tx_start}, 32'd1);
      for (int i = 0; i < 3; i++) serve_frame(1, 4);
      @(negedge wrclk_sig);
      chk("t5_cnt_end", dut.cnt1, 32'd0);
    end

    // Reset while a frame is in SEND.
    do_reset();
    begin
      int nd;
      tx_idle = 1'b0;
      src0_len = 16'd900;
      src0_frame = 1'b1;
      repeat (5) @(negedge wrclk_sig);
      src0_frame = 1'b0;
      chk("t6_cnt0", dut.cnt0, 32'd5);
      push_exp(1'b0, 16'd900);
      tx_idle = 1'b1;
      wait_start();
      repeat (2) @(negedge wrclk_sig);
      tx_idle = 1'b0;
      repeat (4) @(negedge wrclk_sig);
      chk("t6_busy_send", {31'd0, busy}, 32'd1);
      nd = n_done;
      rst = 1'b1;
      exp_q.delete();
      @(negedge wrclk_sig);
      chk("t6_outs", {tx_start, data_length, grant, src_done, busy,
                      err_ovf, err_to}, 32'd0);
      chk("t6_cnt0_clr", dut.cnt0, 32'd0);
      @(negedge wrclk_sig);
      rst = 1'b0;
      repeat (3) @(negedge wrclk_sig);
      tx_idle = 1'b1;
      repeat (10) @(negedge wrclk_sig);
      chk("t6_no_done", n_done - nd, 32'd0);
      chk("t6_idle", {31'd0, busy}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
